// File: rtl/tsc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tsc_pkg : shared constants and state encodings for trigger_surround_cache |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package tsc_pkg;

    localparam int         c_DEPTH  = 32;
    localparam int         c_PRE    = 16;
    localparam logic [7:0] c_THRESH = 8'd200;
    localparam int         c_ADDR_W = $clog2(c_DEPTH);

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_RUNNING   = 4'd1;
    localparam logic [3:0] c_ST_TRIGGERED = 4'd2;
    localparam logic [3:0] c_ST_BUFFERED  = 4'd3;
    localparam logic [3:0] c_ST_SENDING   = 4'd4;

endpackage
`default_nettype wire

// File: rtl/tsc_ring_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tsc_ring_buffer : DEPTH x 8 sample memory, sync write, registered read    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tsc_ring_buffer import tsc_pkg::*; #(
    parameter int DEPTH = c_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Contents are cleared on reset so short-history captures read back zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/trigger_surround_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_surround_cache : captures samples around an ADC threshold trigger |
// | and streams them out oldest-first under a req/rdy handshake.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module trigger_surround_cache import tsc_pkg::*; #(
    parameter int         DEPTH  = c_DEPTH,
    parameter int         PRE    = c_PRE,
    parameter logic [7:0] THRESH = c_THRESH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  adc_data,
    input  logic        req,
    input  logic        sbf,
    output logic        trd,
    output logic        cd,
    output logic        rdy,
    output logic [7:0]  dat,
    output logic [31:0] trigtm,
    output logic        sd
);

    localparam int                  c_AW   = $clog2(DEPTH);
    localparam logic [c_AW-1:0]     c_POST = c_AW'(DEPTH - PRE - 1);
    localparam logic [c_AW-1:0]     c_LAST = c_AW'(DEPTH - 1);

    logic [3:0]      r_current_state;
    logic [31:0]     r_timer;
    logic [31:0]     r_trigtm;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW-1:0] r_pc;
    logic [c_AW-1:0] r_sc;
    logic            r_req_q;
    logic            r_trd;
    logic            r_cd;
    logic            r_rdy;
    logic            r_sd;

    logic            w_req_rise;
    logic            w_post_done;
    logic            w_we;
    logic [7:0]      w_rdata;

    assign w_req_rise  = req & ~r_req_q;
    assign w_post_done = (r_pc == c_POST);
    // The clock that raises cd writes nothing: the post window is already full.
    assign w_we = (r_current_state == c_ST_RUNNING) ||
                  ((r_current_state == c_ST_TRIGGERED) && !w_post_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_current_state <= c_ST_IDLE;
            r_trigtm        <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_pc            <= '0;
            r_sc            <= '0;
            r_req_q         <= 1'b0;
            r_trd           <= 1'b0;
            r_cd            <= 1'b0;
            r_rdy           <= 1'b0;
            r_sd            <= 1'b0;
        end else begin
            r_req_q <= req;
            r_sd    <= 1'b0;
            case (r_current_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_trd           <= 1'b0;
                        r_cd            <= 1'b0;
                        r_current_state <= c_ST_RUNNING;
                    end
                end
                c_ST_RUNNING: begin
                    r_wptr <= r_wptr + 1'b1;
                    if (adc_data >= THRESH) begin
                        r_trd           <= 1'b1;
                        r_trigtm        <= r_timer;
                        r_pc            <= '0;
                        r_current_state <= c_ST_TRIGGERED;
                    end
                end
                c_ST_TRIGGERED: begin
                    if (w_post_done) begin
                        r_cd            <= 1'b1;
                        r_rptr          <= r_wptr;
                        r_current_state <= c_ST_BUFFERED;
                    end else begin
                        r_wptr <= r_wptr + 1'b1;
                        r_pc   <= r_pc + 1'b1;
                    end
                end
                c_ST_BUFFERED: begin
                    if (sbf) begin
                        r_sc            <= '0;
                        r_rdy           <= 1'b1;
                        r_current_state <= c_ST_SENDING;
                    end
                end
                c_ST_SENDING: begin
                    if (w_req_rise) begin
                        r_rptr <= r_rptr + 1'b1;
                        if (r_sc == c_LAST) begin
                            r_rdy           <= 1'b0;
                            r_sd            <= 1'b1;
                            r_current_state <= c_ST_IDLE;
                        end else begin
                            r_sc <= r_sc + 1'b1;
                        end
                    end
                end
                default: r_current_state <= c_ST_IDLE;
            endcase
        end
    end

    tsc_ring_buffer #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (adc_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign trd    = r_trd;
    assign cd     = r_cd;
    assign rdy    = r_rdy;
    assign dat    = w_rdata;
    assign trigtm = r_trigtm;
    assign sd     = r_sd;

endmodule
`default_nettype wire

// File: tb/tb_trigger_surround_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trigger_surround_cache : self-checking bench for trigger_surround_cache|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_trigger_surround_cache;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic [7:0]  adc_data = 8'd0;
    logic        req      = 1'b0;
    logic        sbf      = 1'b0;
    logic        trd;
    logic        cd;
    logic        rdy;
    logic [7:0]  dat;
    logic [31:0] trigtm;
    logic        sd;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] tb_timer = 32'd0;
    logic [7:0]  wq [$];      // every byte the buffer has received, oldest first
    logic [7:0]  stim [$];
    logic        sbf_noise = 1'b0;

    typedef struct {
        logic [7:0] pre;
        logic [7:0] probe;
        logic       exp_trd;
    } bvec_t;
    bvec_t tbl [6];

    trigger_surround_cache dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .adc_data (adc_data),
        .req      (req),
        .sbf      (sbf),
        .trd      (trd),
        .cd       (cd),
        .rdy      (rdy),
        .dat      (dat),
        .trigtm   (trigtm),
        .sd       (sd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) tb_timer = tb_timer + 32'd1;
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_trd"}, trd, 0);
        chk({nm, "_cd"}, cd, 0);
        chk({nm, "_rdy"}, rdy, 0);
        chk({nm, "_dat"}, dat, 0);
        chk({nm, "_trigtm"}, trigtm, 0);
        chk({nm, "_sd"}, sd, 0);
        chk({nm, "_state"}, dut.r_current_state, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; sbf = 1'b0; req = 1'b0; adc_data = 8'd0;
        repeat (2) tick();
        chk_all_zero("rst");
        reset    = 1'b1;
        tb_timer = 32'd0;
        wq.delete();
        repeat (32) wq.push_back(8'd0);
    endtask

    // Plays stim from the clock after start; the first sample >= 200 is the
    // trigger, it plus 16 before/15 after end up in the buffer.
    task automatic run_capture();
        int          ti;
        logic [31:0] exp_tm;
        ti = -1;
        exp_tm = 32'd0;
        for (int i = 0; i < stim.size(); i++) begin
            if (ti < 0 && stim[i] >= 8'd200) ti = i;
        end
        start = 1'b1; adc_data = 8'd255;
        tick();
        start = 1'b0;
        chk("start_state", dut.r_current_state, 1);
        chk("start_trd", trd, 0);
        chk("start_cd", cd, 0);
        sbf = sbf_noise;
        for (int k = 0; k <= ti + 16; k++) begin
            adc_data = stim[k];
            if (k == ti) exp_tm = tb_timer;
            tick();
            chk("cap_trd", trd, (k >= ti) ? 1 : 0);
            chk("cap_cd", cd, (k == ti + 16) ? 1 : 0);
            chk("cap_rdy", rdy, 0);
        end
        sbf = 1'b0;
        chk("cap_trigtm", trigtm, exp_tm);
        chk("cap_state", dut.r_current_state, 3);
        for (int k = 0; k <= ti + 15; k++) wq.push_back(stim[k]);
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("hold_cd", cd, 1);
            chk("hold_rdy", rdy, 0);
        end
    endtask

    task automatic read_out(input int nbytes, input int hold5_at);
        int base;
        int h;
        int g;
        base = wq.size() - 32;
        sbf = 1'b1;
        tick();
        sbf = 1'b0;
        chk("rd_rdy0", rdy, 1);
        chk("rd_state", dut.r_current_state, 4);
        for (int k = 0; k < nbytes; k++) begin
            chk("rd_dat", dat, wq[base + k]);
            chk("rd_rdy", rdy, 1);
            h = (k == hold5_at) ? 5 : int'($urandom_range(1, 3));
            g = int'($urandom_range(1, 2));
            req = 1'b1;
            tick();
            if (k == 31) begin
                chk("rd_sd_pulse", sd, 1);
                chk("rd_rdy_end", rdy, 0);
                chk("rd_state_end", dut.r_current_state, 0);
            end else begin
                chk("rd_sd_mid", sd, 0);
            end
            repeat (h - 1) tick();
            req = 1'b0;
            repeat (g) tick();
            if (k == 31) chk("rd_sd_after", sd, 0);
        end
    endtask

    initial begin
        tbl[0] = '{8'd199, 8'd199, 1'b0};
        tbl[1] = '{8'd199, 8'd200, 1'b1};
        tbl[2] = '{8'd100, 8'd255, 1'b1};
        tbl[3] = '{8'd0,   8'd198, 1'b0};
        tbl[4] = '{8'd198, 8'd201, 1'b1};
        tbl[5] = '{8'd50,  8'd0,   1'b0};

        do_reset();
        repeat (3) tick();
        chk("idle_state", dut.r_current_state, 0);
        chk("idle_trd", trd, 0);
        chk("idle_cd", cd, 0);

        // Threshold boundary, with sbf held high to show it is ignored.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start = 1'b1; adc_data = 8'd255;
            tick();
            start = 1'b0; sbf = 1'b1;
            adc_data = tbl[i].pre;
            tick();
            chk("bnd_pre_trd", trd, 0);
            adc_data = tbl[i].probe;
            tick();
            chk("bnd_trd", trd, tbl[i].exp_trd);
            chk("bnd_state", dut.r_current_state, tbl[i].exp_trd ? 2 : 1);
            chk("bnd_rdy", rdy, 0);
            sbf = 1'b0;
        end

        // Ramp capture and full readout, one request held for 5 clocks.
        do_reset();
        stim.delete();
        for (int v = 0; v <= 216; v++) stim.push_back(8'(v));
        run_capture();
        chk("ramp_first", wq[wq.size() - 32], 8'd184);
        read_out(32, 3);

        // Randomised runs back to back; pointers carry over between runs.
        for (int r = 0; r < 6; r++) begin
            stim.delete();
            repeat ($urandom_range(0, 40)) stim.push_back(8'($urandom_range(0, 199)));
            stim.push_back(8'($urandom_range(200, 255)));
            repeat (16) stim.push_back(8'($urandom_range(0, 255)));
            sbf_noise = 1'($urandom_range(0, 1));
            run_capture();
            read_out(32, int'($urandom_range(0, 31)));
        end
        sbf_noise = 1'b0;

        // Abort during readout, then a short-history capture from clean state.
        stim.delete();
        repeat (20) stim.push_back(8'($urandom_range(0, 199)));
        stim.push_back(8'd230);
        repeat (16) stim.push_back(8'($urandom_range(0, 255)));
        run_capture();
        read_out(10, -1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        do_reset();
        stim.delete();
        stim.push_back(8'd255);
        repeat (16) stim.push_back(8'($urandom_range(0, 255)));
        run_capture();
        read_out(32, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
